// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR stream scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_ctrl_pkg;

  localparam int SAMPLE_W = 16;
  localparam int BATCH_N  = 1000;
  localparam int CNT_W    = 10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    COEFF_START,
    COEFF_WAIT
  } sched_state_t;

endpackage

// File: rtl/fir_result_fifo.sv
// Synchronous result FIFO holding {err, fir_out} entries with an occupancy count.
// Latency: a push is visible at the head one cycle later; head is read combinationally.
// Backpressure: push ignored when full unless a pop happens on the same cycle; pop ignored when empty.
module fir_result_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic          pop_vld,
  output logic [W-1:0]  pop_dat,
  output logic [AW:0]   count,
  output logic          full
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == DEPTH_C);
  assign pop_vld = (count_q != '0);
  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next-state for storage, pointers and occupancy; simultaneous push/pop when full keeps count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers with synchronous flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fir_stream_scheduler.sv
// Arbitrates the shared FIR datapath between the sample stream and coefficient reloads.
// Latency: sample accept -> data_ready next cycle; filter done -> out_valid next cycle.
// Backpressure: in_ready only while idle, no reload pending and the result FIFO has credit.
module fir_stream_scheduler
  import fir_ctrl_pkg::*;
#(
  parameter int OUT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  input  logic                coeff_req,
  output logic                coeff_start,
  input  logic                coeff_busy,
  output logic                data_ready,
  output logic [SAMPLE_W-1:0] sample_data,
  input  logic                modwait,
  input  logic [SAMPLE_W-1:0] fir_out,
  input  logic                err,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_err,
  input  logic                out_ready,
  output logic                one_k_samples
);

  localparam int AW = $clog2(OUT_DEPTH);

  sched_state_t        state_q, state_d;
  logic [SAMPLE_W-1:0] sample_data_q, sample_data_d;
  logic                data_ready_q, data_ready_d;
  logic                coeff_start_q, coeff_start_d;
  logic                one_k_q, one_k_d;
  logic [CNT_W-1:0]    bcount_q, bcount_d;

  logic [AW:0]         fifo_count;
  logic                fifo_full;
  logic                inflight;
  logic                credit_ok;
  logic                push;

  // One sample is in flight from ISSUE until its result is pushed; it has a reserved FIFO slot.
  assign inflight  = (state_q == ISSUE) || (state_q == WAIT_DONE);
  assign credit_ok = (int'(fifo_count) + int'(inflight)) < OUT_DEPTH;
  assign in_ready  = (state_q == IDLE) && !coeff_req && credit_ok;
  assign push      = (state_q == WAIT_DONE) && !modwait;

  assign data_ready    = data_ready_q;
  assign sample_data   = sample_data_q;
  assign coeff_start   = coeff_start_q;
  assign one_k_samples = one_k_q;

  fir_result_fifo #(
    .W     (SAMPLE_W + 1),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({err, fir_out}),
    .pop      (out_ready),
    .pop_vld  (out_valid),
    .pop_dat  ({out_err, out_data}),
    .count    (fifo_count),
    .full     (fifo_full)
  );

  // State register plus registered outputs and batch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sample_data_q <= '0;
      data_ready_q  <= 1'b0;
      coeff_start_q <= 1'b0;
      one_k_q       <= 1'b0;
      bcount_q      <= '0;
    end else begin
      state_q       <= state_d;
      sample_data_q <= sample_data_d;
      data_ready_q  <= data_ready_d;
      coeff_start_q <= coeff_start_d;
      one_k_q       <= one_k_d;
      bcount_q      <= bcount_d;
    end
  end

  // Next-state: a reload request wins over a sample offered on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (coeff_req && !modwait)    state_d = COEFF_START;
        else if (in_valid && in_ready) state_d = ISSUE;
      end
      ISSUE:       if (modwait)     state_d = WAIT_DONE;
      WAIT_DONE:   if (!modwait)    state_d = IDLE;
      COEFF_START:                  state_d = COEFF_WAIT;
      COEFF_WAIT:  if (!coeff_busy) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Output next-values: data_ready held until the filter reports busy; coeff_start is one cycle.
  always_comb begin
    sample_data_d = sample_data_q;
    data_ready_d  = 1'b0;
    coeff_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (coeff_req && !modwait) begin
          coeff_start_d = 1'b1;
        end else if (in_valid && in_ready) begin
          data_ready_d  = 1'b1;
          sample_data_d = in_data;
        end
      end
      ISSUE:   data_ready_d = !modwait;
      default: data_ready_d = 1'b0;
    endcase
  end

  // Result counter: wraps at BATCH_N with a one-cycle pulse; a completed reload restarts it.
  always_comb begin
    bcount_d = bcount_q;
    one_k_d  = 1'b0;
    if (push) begin
      if (bcount_q == CNT_W'(BATCH_N - 1)) begin
        bcount_d = '0;
        one_k_d  = 1'b1;
      end else begin
        bcount_d = bcount_q + 1'b1;
      end
    end
    if ((state_q == COEFF_WAIT) && !coeff_busy) begin
      bcount_d = '0;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_fir_stream_scheduler.sv
module tb_fir_stream_scheduler;
  import fir_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic [SAMPLE_W-1:0] in_data;
  logic                in_ready;
  logic                coeff_req;
  logic                coeff_start;
  logic                coeff_busy;
  logic                data_ready;
  logic [SAMPLE_W-1:0] sample_data;
  logic                modwait;
  logic [SAMPLE_W-1:0] fir_out;
  logic                err;
  logic                out_valid;
  logic [SAMPLE_W-1:0] out_data;
  logic                out_err;
  logic                out_ready;
  logic                one_k_samples;

  int checks = 0;
  int errors = 0;
  int issued = 0;
  int fin = 0;
  int k_pulses = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  fir_stream_scheduler #(.OUT_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .coeff_req     (coeff_req),
    .coeff_start   (coeff_start),
    .coeff_busy    (coeff_busy),
    .data_ready    (data_ready),
    .sample_data   (sample_data),
    .modwait       (modwait),
    .fir_out       (fir_out),
    .err           (err),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_err       (out_err),
    .out_ready     (out_ready),
    .one_k_samples (one_k_samples)
  );

  // Stand-in filter arithmetic: result = sample + 0x1134, overflow flagged when result is 0x7FFF.
  function automatic logic [16:0] filt(input logic [15:0] s);
    logic [15:0] r;
    r = s + 16'h1134;
    return {(r == 16'h7FFF), r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Filter model: busy 2 cycles after data_ready is seen, for 4 cycles; result on the fall.
  initial begin : filter_model
    logic [16:0] r;
    modwait = 1'b0;
    fir_out = '0;
    err     = 1'b0;
    forever begin
      @(negedge clk);
      if (data_ready && !rst) begin
        r = filt(sample_data);
        issued++;
        repeat (2) @(negedge clk);
        modwait = 1'b1;
        fir_out = 16'hDEAD;
        err     = 1'b0;
        repeat (4) @(negedge clk);
        modwait = 1'b0;
        fir_out = r[15:0];
        err     = r[16];
        fin++;
      end
    end
  end

  // Scoreboard monitor: compares each popped result against the oldest expected entry.
  initial begin : monitor
    logic [16:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {15'b0, out_err, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard", {15'b0, out_err, out_data}, {15'b0, e});
        end
      end
    end
  end

  always @(negedge clk) if (one_k_samples === 1'b1) k_pulses++;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one sample for up to max cycles; called and returns just after a falling edge.
  task automatic offer(input logic [15:0] d, input int max, output logic acc);
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < max && !acc; i++) begin
      #1;
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back(filt(d));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_wait_done(input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = modwait && !data_ready;
    end
    check("reach_wait_done", seen, 1);
  endtask

  initial begin : stimulus
    logic acc;
    int   n, base_iss, base_fin, base_k, bad;
    logic found;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; coeff_req = 1'b0;
    coeff_busy = 1'b0; out_ready = 1'b0;

    // 1: reset values
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_data_ready", data_ready, 0);
    check("rst_coeff_start", coeff_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_one_k", one_k_samples, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // 2: single sample latency
    offer(16'h0100, 5, acc);
    check("t2_accept", acc, 1);
    #1;
    check("t2_data_ready", data_ready, 1);
    check("t2_sample_data", sample_data, 16'h0100);
    repeat (6) @(negedge clk);
    #1;
    check("t2_out_valid_c7", out_valid, 0);
    @(negedge clk); #1;
    check("t2_out_valid_c8", out_valid, 1);
    check("t2_out_data", out_data, 16'h1234);
    check("t2_out_err", out_err, 0);
    out_ready = 1'b1;
    wait_drain(20);

    // 3: credit limit with a stalled consumer
    out_ready = 1'b0;
    @(negedge clk);
    base_iss = issued;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      offer(16'h0200 + 16'(i), 40, acc);
      if (acc) n++;
    end
    check("t3_four_accepted", n, 4);
    offer(16'h0300, 30, acc);
    check("t3_fifth_blocked", acc, 0);
    check("t3_in_ready_low", in_ready, 0);
    check("t3_issued4", issued - base_iss, 4);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    offer(16'h0301, 30, acc);
    check("t3_after_pop_accept", acc, 1);
    offer(16'h0302, 30, acc);
    check("t3_sixth_blocked", acc, 0);
    check("t3_issued5", issued - base_iss, 5);
    out_ready = 1'b1;
    wait_drain(100);

    // 4: reload requested while a result is in flight
    offer(16'h0400, 5, acc);
    check("t4_accept", acc, 1);
    base_fin = fin;
    wait_wait_done(20);
    coeff_req = 1'b1;
    #1;
    check("t4_in_ready_req", in_ready, 0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #1;
      found = coeff_start;
    end
    check("t4_coeff_start_seen", found, 1);
    check("t4_result_before_reload", exp_q.size(), 0);
    check("t4_fin", fin - base_fin, 1);
    coeff_req  = 1'b0;
    coeff_busy = 1'b1;
    @(negedge clk); #1;
    check("t4_coeff_start_pulse", coeff_start, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (in_ready) bad++;
    end
    check("t4_in_ready_busy", bad, 0);
    coeff_busy = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("t4_in_ready_after", in_ready, 1);

    // 5: overflow flag travels with its own entry only
    @(negedge clk);
    out_ready = 1'b0;
    offer(16'h6ECB, 20, acc);
    offer(16'h0001, 20, acc);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #1;
      found = out_valid;
    end
    check("t5_out_data", out_data, 16'h7FFF);
    check("t5_out_err", out_err, 1);
    out_ready = 1'b1;
    wait_drain(40);

    // 7: reset mid-operation
    out_ready = 1'b0;
    @(negedge clk);
    offer(16'h0700, 20, acc);
    offer(16'h0701, 20, acc);
    offer(16'h0702, 20, acc);
    base_fin = fin;
    wait_wait_done(20);
    check("t7_two_queued", out_valid, 1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("t7_out_valid_rst", out_valid, 0);
    check("t7_data_ready_rst", data_ready, 0);
    exp_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 20 && fin == base_fin; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    check("t7_late_fall_no_push", out_valid, 0);

    // 6: batch pulses
    out_ready = 1'b1;
    @(negedge clk);
    base_k = k_pulses;
    n = 0;
    for (int i = 0; i < 999; i++) begin
      offer(16'(i * 7), 40, acc);
      if (acc) n++;
    end
    wait_drain(40);
    check("t6_no_pulse_999", k_pulses - base_k, 0);
    offer(16'h0999, 40, acc);
    if (acc) n++;
    wait_drain(40);
    check("t6_pulse_1000", k_pulses - base_k, 1);
    for (int i = 0; i < 1000; i++) begin
      offer(16'(i * 5), 40, acc);
      if (acc) n++;
    end
    wait_drain(40);
    check("t6_pulse_2000", k_pulses - base_k, 2);
    check("t6_accepted", n, 2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
